// File: rtl/uart_io_responder_if.sv
// ---------------------------------------------------------------------------
// uart_io_responder_if
// Byte I/O handshake bundle between the execution core and the UART responder.
//   uart_in_data   [7:0]  core -> responder, byte to transmit (OUT)
//   uart_in_valid         core -> responder, uart_in_data is offered
//   uart_in_ready         responder -> core, TX FIFO can take a byte
//   uart_out_valid        core -> responder, request one received byte (IN)
//   uart_out_data  [7:0]  responder -> core, RX FIFO head byte
//   uart_out_ready        responder -> core, RX FIFO holds at least one byte
// The core side uses the master modport, the responder the slave modport.
// ---------------------------------------------------------------------------
interface uart_io_responder_if;
   logic [7:0] uart_in_data;
   logic       uart_in_valid;
   logic       uart_in_ready;
   logic       uart_out_valid;
   logic [7:0] uart_out_data;
   logic       uart_out_ready;

   modport master (
      output uart_in_data,
      output uart_in_valid,
      output uart_out_valid,
      input  uart_in_ready,
      input  uart_out_data,
      input  uart_out_ready
   );

   modport slave (
      input  uart_in_data,
      input  uart_in_valid,
      input  uart_out_valid,
      output uart_in_ready,
      output uart_out_data,
      output uart_out_ready
   );
endinterface

// File: rtl/uart_io_responder.sv
// ---------------------------------------------------------------------------
// uart_io_responder
// UART side of the core's byte I/O. OUT bytes are queued in a TX FIFO and sent
// 8N1 on uart_tx; uart_rx is deserialised into an RX FIFO that answers IN
// requests from its head.
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (>= 4)
//   FIFO_AW       FIFO address width, each FIFO holds 2**FIFO_AW bytes
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   bus           uart_io_responder_if.slave handshake bundle
//   uart_tx       serial output, idle high
//   uart_rx       serial input, asynchronous to clk
//   rx_overflow   sticky, a good frame was dropped on a full RX FIFO
//   rx_frame_err  sticky, a frame with a low stop bit was discarded
// Build option: define UART_LOOPBACK_EN to feed the internal TX line into the
// receiver; uart_tx is then held high and uart_rx is ignored.
// ---------------------------------------------------------------------------
module uart_io_responder #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_AW      = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   uart_io_responder_if.slave bus,
   output logic               uart_tx,
   input  logic               uart_rx,
   output logic               rx_overflow,
   output logic               rx_frame_err
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int CW    = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]    BIT_LAST   = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]    HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

   // TX FIFO
   logic [7:0]         tx_mem [DEPTH];
   logic [FIFO_AW-1:0] tx_wr_ptr, tx_rd_ptr;
   logic [FIFO_AW:0]   tx_count;
   logic               tx_full, tx_empty, tx_push, tx_pop;

   // TX serialiser
   tx_state_t          tx_state;
   logic [CW-1:0]      tx_cnt;
   logic [2:0]         tx_bit;
   logic [7:0]         tx_shift;
   logic               tx_line;

   // RX FIFO
   logic [7:0]         rx_mem [DEPTH];
   logic [FIFO_AW-1:0] rx_wr_ptr, rx_rd_ptr;
   logic [FIFO_AW:0]   rx_count;
   logic               rx_full, rx_empty, rx_push, rx_pop;

   // RX deserialiser
   rx_state_t          rx_state;
   logic [CW-1:0]      rx_cnt;
   logic [2:0]         rx_bit;
   logic [7:0]         rx_shift;
   logic               rx_in, rx_s1, rx_s2, rx_prev;

`ifdef UART_LOOPBACK_EN
   assign rx_in   = tx_line;
   assign uart_tx = 1'b1;
`else
   assign rx_in   = uart_rx;
   assign uart_tx = tx_line;
`endif

   // Handshake outputs come straight from registered FIFO state. Fullness is
   // judged before the edge, so a pop never lets a push into a full FIFO.
   assign tx_full  = (tx_count == FULL_COUNT);
   assign tx_empty = (tx_count == '0);
   assign rx_full  = (rx_count == FULL_COUNT);
   assign rx_empty = (rx_count == '0);

   assign bus.uart_in_ready  = !tx_full;
   assign bus.uart_out_ready = !rx_empty;
   assign bus.uart_out_data  = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];

   assign tx_push = bus.uart_in_valid && !tx_full;
   assign rx_pop  = bus.uart_out_valid && !rx_empty;

   // The serialiser takes the head either from idle or at the end of a stop
   // bit, which is what makes back-to-back frames gapless.
   assign tx_pop = !tx_empty &&
                   ((tx_state == TX_IDLE) ||
                    ((tx_state == TX_STOP) && (tx_cnt == BIT_LAST)));

   // A good stop bit stores the byte unless the FIFO was already full.
   assign rx_push = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST) && rx_s2 && !rx_full;

   // FIFO storage is plain memory; only pointers and counts are reset.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= bus.uart_in_data;
      if (rx_push) rx_mem[rx_wr_ptr] <= rx_shift;
   end

   // Pointer and occupancy bookkeeping for both FIFOs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
         tx_count <= tx_count + (FIFO_AW + 1)'(tx_push) - (FIFO_AW + 1)'(tx_pop);
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
         rx_count <= rx_count + (FIFO_AW + 1)'(rx_push) - (FIFO_AW + 1)'(rx_pop);
      end
   end

   // Transmit FSM, LSB first; tx_line is the registered serial output.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx_line  <= 1'b1;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (tx_pop) begin
                  tx_shift <= tx_mem[tx_rd_ptr];
                  tx_cnt   <= '0;
                  tx_line  <= 1'b0;
                  tx_state <= TX_START;
               end
            end
            TX_START: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt   <= '0;
                  tx_bit   <= '0;
                  tx_line  <= tx_shift[0];
                  tx_state <= TX_DATA;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            TX_DATA: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt <= '0;
                  if (tx_bit == 3'd7) begin
                     tx_line  <= 1'b1;
                     tx_state <= TX_STOP;
                  end else begin
                     tx_bit   <= tx_bit + 1'b1;
                     tx_shift <= tx_shift >> 1;
                     tx_line  <= tx_shift[1];
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            TX_STOP: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt <= '0;
                  if (tx_pop) begin
                     tx_shift <= tx_mem[tx_rd_ptr];
                     tx_line  <= 1'b0;
                     tx_state <= TX_START;
                  end else begin
                     tx_state <= TX_IDLE;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            default: begin
               tx_line  <= 1'b1;
               tx_state <= TX_IDLE;
            end
         endcase
      end
   end

   // Receive FSM behind a two-flop synchroniser. The start bit is re-checked
   // at its middle, after which every sample falls mid-bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_s1        <= 1'b1;
         rx_s2        <= 1'b1;
         rx_prev      <= 1'b1;
         rx_state     <= RX_IDLE;
         rx_cnt       <= '0;
         rx_bit       <= '0;
         rx_shift     <= '0;
         rx_overflow  <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         rx_s1   <= rx_in;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
         case (rx_state)
            RX_IDLE: begin
               if (rx_prev && !rx_s2) begin
                  rx_cnt   <= '0;
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (rx_cnt == HALF_LAST) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_s2, rx_shift[7:1]};
                  if (rx_bit == 3'd7) rx_state <= RX_STOP;
                  else                rx_bit   <= rx_bit + 1'b1;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt <= '0;
                  if (rx_s2) begin
                     if (rx_full) rx_overflow <= 1'b1;
                     rx_state <= RX_IDLE;
                  end else begin
                     rx_frame_err <= 1'b1;
                     rx_state     <= RX_WAIT_HIGH;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_WAIT_HIGH: begin
               if (rx_s2) rx_state <= RX_IDLE;
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_io_responder.sv
// ---------------------------------------------------------------------------
// tb_uart_io_responder
// Self-checking bench for uart_io_responder with CLKS_PER_BIT=4, FIFO_AW=2.
// A transaction-level model tracks the TX FIFO as a queue plus a frame timer,
// predicts the uart_tx waveform from each byte's 8N1 frame, and keeps the
// bytes the RX FIFO should hold plus the sticky flags. Honours
// UART_LOOPBACK_EN the same way the design does.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_io_responder;
   localparam int CPB   = 4;
   localparam int AW    = 2;
   localparam int DEPTH = 1 << AW;
   localparam int FRAME = 10 * CPB;

   logic clk          = 1'b0;
   logic reset_n      = 1'b1;
   logic uart_rx      = 1'b1;
   logic uart_tx;
   logic rx_overflow;
   logic rx_frame_err;

   uart_io_responder_if bus();

   uart_io_responder #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .bus          (bus),
      .uart_tx      (uart_tx),
      .uart_rx      (uart_rx),
      .rx_overflow  (rx_overflow),
      .rx_frame_err (rx_frame_err)
   );

   always #5 clk = ~clk;

   int errorCount = 0;
   int checkCount = 0;

   // Reference model state.
   byte unsigned txSrc[$];
   byte unsigned txFifo[$];
   bit           txActive;
   int           txTimer;
   bit           expWave[$];
   bit           rxWave[$];
   byte unsigned rxExp[$];
   bit           expOverflow;
   bit           expFrameErr;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Serial level of bit k of an 8N1 frame carrying b.
   function automatic bit frameBit(input logic [7:0] b, input bit stopOk, input int k);
      int slot;
      slot = k / CPB;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[slot-1];
      return stopOk;
   endfunction

   function automatic void modelRxFrame(input byte unsigned b, input bit stopOk);
      if (!stopOk)                   expFrameErr = 1'b1;
      else if (rxExp.size() == DEPTH) expOverflow = 1'b1;
      else                           rxExp.push_back(b);
   endfunction

   function automatic void addTxFrame(input byte unsigned b);
`ifdef UART_LOOPBACK_EN
      modelRxFrame(b, 1'b1);
`else
      for (int k = 0; k < FRAME; k++) expWave.push_back(frameBit(b, 1'b1, k));
`endif
   endfunction

   function automatic void sendRxFrame(input byte unsigned b, input bit stopOk);
      for (int k = 0; k < FRAME; k++) rxWave.push_back(frameBit(b, stopOk, k));
      if (!stopOk) for (int k = 0; k < 2 * CPB; k++) rxWave.push_back(1'b1);
`ifndef UART_LOOPBACK_EN
      modelRxFrame(b, stopOk);
`endif
   endfunction

   function automatic void sendRxGlitch();
      rxWave.push_back(1'b0);
      for (int k = 0; k < FRAME; k++) rxWave.push_back(1'b1);
   endfunction

   // Advance the TX model across one clock edge.
   function automatic void txStep();
      bit push;
      bit popNow;
      byte unsigned b;
      push   = bus.uart_in_valid && (txFifo.size() < DEPTH);
      popNow = 1'b0;
      if (!txActive) begin
         popNow = (txFifo.size() > 0);
      end else begin
         txTimer--;
         if (txTimer == 0) begin
            if (txFifo.size() > 0) popNow = 1'b1;
            else                   txActive = 1'b0;
         end
      end
      if (popNow) begin
         b        = txFifo.pop_front();
         txActive = 1'b1;
         txTimer  = FRAME;
         addTxFrame(b);
      end
      if (push) txFifo.push_back(txSrc.pop_front());
   endfunction

   // One clock: check outputs against the model, drive inputs, step the model.
   task automatic applyStimulus(input bit popReq);
      @(negedge clk);
      checkOutput("uart_tx", uart_tx, (expWave.size() > 0) ? expWave.pop_front() : 1'b1);
      checkOutput("in_ready", bus.uart_in_ready, txFifo.size() < DEPTH);
      if (popReq) begin
         checkOutput("out_ready", bus.uart_out_ready, 1'b1);
         checkOutput("out_data", bus.uart_out_data, rxExp.pop_front());
      end
      bus.uart_out_valid = popReq;
      bus.uart_in_valid  = (txSrc.size() > 0);
      bus.uart_in_data   = (txSrc.size() > 0) ? txSrc[0] : 8'h00;
      uart_rx            = (rxWave.size() > 0) ? rxWave.pop_front() : 1'b1;
      txStep();
   endtask

   task automatic runCycles(input int n);
      for (int c = 0; c < n; c++) applyStimulus(1'b0);
   endtask

   task automatic drainRx();
      while (rxExp.size() > 0) applyStimulus(1'b1);
      applyStimulus(1'b0);
      checkOutput("out_ready_drained", bus.uart_out_ready, 1'b0);
   endtask

   task automatic checkSticky();
      checkOutput("rx_overflow", rx_overflow, expOverflow);
      checkOutput("rx_frame_err", rx_frame_err, expFrameErr);
   endtask

   task automatic applyReset(input bit midFrame);
      @(negedge clk);
      if (midFrame) checkOutput("tx_before_reset", uart_tx, (expWave.size() > 0) ? expWave[0] : 1'b1);
      reset_n            = 1'b0;
      bus.uart_in_valid  = 1'b0;
      bus.uart_out_valid = 1'b0;
      bus.uart_in_data   = 8'h00;
      uart_rx            = 1'b1;
      #1;
      checkOutput("reset_uart_tx", uart_tx, 1'b1);
      checkOutput("reset_in_ready", bus.uart_in_ready, 1'b1);
      checkOutput("reset_out_ready", bus.uart_out_ready, 1'b0);
      checkOutput("reset_out_data", bus.uart_out_data, 8'h00);
      checkOutput("reset_overflow", rx_overflow, 1'b0);
      checkOutput("reset_frame_err", rx_frame_err, 1'b0);
      txSrc.delete();
      txFifo.delete();
      expWave.delete();
      rxWave.delete();
      rxExp.delete();
      txActive    = 1'b0;
      txTimer     = 0;
      expOverflow = 1'b0;
      expFrameErr = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.uart_in_valid  = 1'b0;
      bus.uart_in_data   = 8'h00;
      bus.uart_out_valid = 1'b0;
      applyReset(1'b0);

      // Single frame with a known pattern, then a gapless burst that fills the FIFO.
      txSrc.push_back(8'hA5);
      runCycles(FRAME + 30);
      for (int i = 0; i < 6; i++) txSrc.push_back(8'($urandom_range(0, 255)));
      runCycles(6 * FRAME + 30);
      drainRx();
      checkSticky();

      // One received byte answered by an IN.
      sendRxFrame(8'h3C, 1'b1);
      runCycles(FRAME + 30);
      checkSticky();
      drainRx();

      // Overflow, then a bad stop bit, then a start glitch.
      for (int i = 0; i < 5; i++) sendRxFrame(8'($urandom_range(0, 255)), 1'b1);
      runCycles(5 * FRAME + 30);
      checkSticky();
      sendRxFrame(8'($urandom_range(0, 255)), 1'b0);
      runCycles(FRAME + 3 * CPB + 30);
      checkSticky();
      sendRxGlitch();
      runCycles(FRAME + 10);
      checkSticky();
      drainRx();

      // Random traffic in both directions at once.
      for (int i = 0; i < 3; i++) begin
         txSrc.push_back(8'($urandom_range(0, 255)));
         sendRxFrame(8'($urandom_range(0, 255)), 1'b1);
      end
      runCycles(3 * FRAME + 40);
      checkSticky();
      drainRx();

      // Reset while a TX frame and an RX frame are both in flight.
      txSrc.push_back(8'h00);
      sendRxFrame(8'($urandom_range(0, 255)), 1'b1);
      runCycles(10);
      applyReset(1'b1);
      runCycles(FRAME + 10);
      checkSticky();
      drainRx();

      // Loopback-style sequence; with pins it checks the frames on uart_tx.
      txSrc.push_back(8'h00);
      txSrc.push_back(8'hFF);
      txSrc.push_back(8'h5A);
      runCycles(3 * FRAME + 30);
      drainRx();
      checkSticky();

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end
endmodule
